// File: rtl/frame_loader.sv
// ============================================================================
//  Module   : frame_loader
//  Brief    : Streams one sop-aligned frame of 32-bit pixels into SDRAM
//             through a single-entry Avalon-MM write register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_loader #(
   parameter int H_PIXELS = 640,
   parameter int V_LINES  = 480,
   parameter int ADDR_W   = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              sop_error,
   input  logic              pix_valid,
   input  logic [31:0]       pix_data,
   input  logic              pix_sop,
   output logic              pix_ready,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest
);

   localparam int               TOTAL      = H_PIXELS * V_LINES;
   localparam int               CNT_W      = $clog2(TOTAL + 1);
   localparam logic [CNT_W-1:0] TOTAL_CNT  = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TOTAL - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_SOP = 2'd1,
      S_XFER     = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  beats_taken;
   logic [CNT_W-1:0]  writes_done;
   logic              start_fire;
   logic              beat_fire;
   logic              write_fire;
   logic              sop_load;
   logic              xfer_load;
   logic              load;
   logic [ADDR_W-1:0] beat_addr;

   assign start_fire     = start && (state == S_IDLE);
   assign beat_fire      = pix_valid && pix_ready;
   assign write_fire     = avm_write && !avm_waitrequest;
   assign sop_load       = (state == S_WAIT_SOP) && beat_fire && pix_sop;
   assign xfer_load      = (state == S_XFER) && beat_fire;
   assign load           = sop_load || xfer_load;
   // beats_taken is still zero for the sop beat, so pixel 0 lands on base.
   assign beat_addr      = base_q + (ADDR_W'(beats_taken) << 2);
   assign busy           = (state != S_IDLE);
   assign done           = (state == S_DONE);
   assign avm_byteenable = 4'hF;

   always_comb begin
      state_nxt = state;
      pix_ready = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_WAIT_SOP;
         end
         S_WAIT_SOP: begin
            pix_ready = 1'b1;
            if (pix_valid && pix_sop) state_nxt = S_XFER;
         end
         S_XFER: begin
            // Refill in the same cycle the held write drains: 1 word/clock.
            pix_ready = (!avm_write || !avm_waitrequest) && (beats_taken < TOTAL_CNT);
            if (write_fire && (writes_done == LAST_CNT)) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base_q      <= '0;
         beats_taken <= '0;
         writes_done <= '0;
         sop_error   <= 1'b0;
      end else begin
         if (start_fire) begin
            base_q      <= base_addr;
            beats_taken <= '0;
            writes_done <= '0;
            sop_error   <= 1'b0;
         end else begin
            if (load) beats_taken <= beats_taken + 1'b1;
            if (write_fire) writes_done <= writes_done + 1'b1;
            // A stray sop mid-frame is flagged but the beat is kept as data.
            if (xfer_load && pix_sop) sop_error <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
      end else begin
         if (load) begin
            avm_write     <= 1'b1;
            avm_address   <= beat_addr;
            avm_writedata <= pix_data;
         end else if (write_fire) begin
            avm_write <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Producer-side counterpart of the frame buffer read path. It accepts a streaming pixel source (Avalon-ST sink, 32-bit pixels, start-of-packet marked) and writes one full frame of pixels as consecutive 32-bit words into SDRAM through an Avalon-MM write master.
- Sits between any image source (JTAG-fed FIFO, pattern generator) and the SDRAM controller port that the frame buffer DMA later reads for VGA scan-out.

Parameters:
H_PIXELS, 640, active pixels per line
V_LINES, 480, active lines per frame
ADDR_W, 32, Avalon-MM byte address width
TOTAL (localparam), H_PIXELS*V_LINES, words written per frame

Ports:
clock  in  1  single clock for all logic
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to load a frame; ignored unless IDLE
base_addr  in  ADDR_W  frame byte base address; latched on accepted start; must be 4-byte aligned
busy  out  1  high from accepted start until the cycle done pulses, inclusive
done  out  1  one-cycle pulse when the final write is accepted by the slave
sop_error  out  1  sticky; set when pix_sop arrives on any beat other than pixel 0 of a frame; cleared by accepted start or reset
pix_valid  in  1  Avalon-ST valid
pix_data  in  32  pixel {8'h00,R,G,B}
pix_sop  in  1  Avalon-ST startofpacket, first pixel of a frame
pix_ready  out  1  Avalon-ST ready (readyLatency 0)
avm_address  out  ADDR_W  byte address
avm_write  out  1  write request
avm_writedata  out  32  write data
avm_byteenable  out  4  constant 4'hF
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (async assert, sync deassert usage): state IDLE; busy=0, done=0, sop_error=0, pix_ready=0, avm_write=0, avm_address=0, avm_writedata=0; all counters 0. Reset mid-frame abandons the frame; avm_write drops immediately.
- FSM states and transitions:
  - IDLE: on start=1, latch base_addr, clear counters and sop_error, go to WAIT_SOP.
  - WAIT_SOP: pix_ready=1. Beats without pix_sop are consumed and discarded. A beat with pix_sop=1 is pixel 0: it is loaded into the write register and the state goes to XFER.
  - XFER: stream pixels into writes until accepted count reaches TOTAL, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1 in that cycle, then IDLE.
- Write register holds one entry: avm_write/avm_address/avm_writedata.
  - Loaded on a beat with pix_valid and pix_ready both high: avm_writedata=pix_data, avm_address=base+4*beat_index, avm_write=1.
  - A write is accepted when avm_write=1 and avm_waitrequest=0.
  - While avm_waitrequest=1, address, data and write are held stable.
- pix_ready in XFER = (avm_write==0 or avm_waitrequest==0) and beats_taken<TOTAL. A new beat may be loaded in the same cycle the previous write is accepted, giving 1 word/clock sustained with no stall.
- Latency: pixel accepted at cycle n appears on avm_write at cycle n+1.
- Counters are clog2(TOTAL+1) bits wide:
  - beats_taken increments on every ST beat accepted in XFER, including the loading sop beat from WAIT_SOP.
  - writes_done increments on every accepted write.
  - XFER→DONE happens in the cycle writes_done becomes TOTAL. No address wraps within a frame.
- pix_sop on beat index ≠0 in XFER: set sop_error, treat the beat as ordinary data (no resync).
- start while busy: ignored, no effect on counters or latched base.
- After beats_taken reaches TOTAL, pix_ready=0 until the next frame's WAIT_SOP.

Test Plan (H_PIXELS=4, V_LINES=2, TOTAL=8, base_addr=32'h0000_1000):
- Ideal stream: start, 8 beats data 1..8 with sop on the first, valid every cycle, waitrequest=0 → writes to 0x1000,0x1004..0x101C with data 1..8 on 8 consecutive cycles; done pulses once, the cycle after the 8th write is accepted; busy falls with it.
- Leading junk: 3 beats without sop, then the sop frame → junk consumed (ready=1) and never written; first write is at 0x1000 with the sop beat's data.
- Backpressure: waitrequest high 3 cycles on write 2, and every other cycle thereafter → address/data stable throughout each stall; pix_ready low during stalls; exactly 8 writes, in order, no duplicates.
- Bubbles: pix_valid toggling 1,0,1,0 → avm_write low during gaps; addresses still contiguous; done after the 8th write.
- Mid-frame sop at beat 5 → sop_error=1 and stays set; beat written to 0x1014; frame completes normally; the next accepted start clears sop_error.
- Reset asserted after write 3 → all outputs zero asynchronously; after release with start, the frame restarts at 0x1000; start pulsed while busy changes nothing.
